// File: rtl/soc_system_pcp_0_benchmark_timestamper.sv
// Benchmark-pin edge timestamper: edge detection on the PCP benchmark PIO,
// free-running tick counter and an event FIFO that is drained over Avalon-MM.
module soc_system_pcp_0_benchmark_timestamper #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_AW     = 4,
  parameter int TS_PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pin_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int                PW       = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(TS_PRESCALE - 1);
  localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic               r_enable;
  logic               r_irq_en;
  logic [7:0]         r_rmask;
  logic [7:0]         r_fmask;
  logic [7:0]         r_prev_pins;
  logic [31:0]        r_counter;
  logic [PW-1:0]      r_prescale;
  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_overflow;

  logic [7:0]  w_rise;
  logic [7:0]  w_fall;
  logic        w_edge_push;
  logic        w_do_push;
  logic        w_pop;
  logic        w_empty;
  logic        w_full;
  logic        w_wr;
  logic        w_rd;
  logic        w_clear;
  logic        w_unused;

  assign w_wr        = chipselect & ~write_n;
  assign w_rd        = chipselect & ~read_n;
  assign w_clear     = w_wr & (address == 3'd0) & writedata[2];
  assign w_rise      = pin_in & ~r_prev_pins & r_rmask;
  assign w_fall      = ~pin_in & r_prev_pins & r_fmask;
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == LVL_FULL);
  assign w_edge_push = r_enable & (|(w_rise | w_fall));
  assign w_pop       = w_rd & (address == 3'd4) & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push   = w_edge_push & (~w_full | w_pop) & ~w_clear;
  assign irq         = r_irq_en & ~w_empty;
  assign w_unused    = ^writedata[31:8];

  // Control and mask registers plus the pin history used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_rmask     <= 8'hFF;
      r_fmask     <= 8'hFF;
      r_prev_pins <= 8'h00;
    end else begin
      r_prev_pins <= pin_in;
      if (w_wr) begin
        case (address)
          3'd0:    begin r_enable <= writedata[0]; r_irq_en <= writedata[1]; end
          3'd2:    r_rmask <= writedata[7:0];
          3'd3:    r_fmask <= writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  // Prescaler and tick counter; both hold while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter  <= 32'd0;
      r_prescale <= '0;
    end else if (w_clear) begin
      r_counter  <= 32'd0;
      r_prescale <= '0;
    end else if (r_enable) begin
      if (r_prescale == PRE_LAST) begin
        r_prescale <= '0;
        r_counter  <= r_counter + 32'd1;
      end else begin
        r_prescale <= r_prescale + PW'(1);
      end
    end
  end

  // Event storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= {w_rise, w_fall, r_counter[15:0]};
    end
  end

  // FIFO pointers, fill level and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_do_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_wr && (address == 3'd1)) begin
        r_overflow <= 1'b0;
      end else if (w_edge_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'd0;
    if (w_rd) begin
      case (address)
        3'd0: readdata = {30'd0, r_irq_en, r_enable};
        3'd1: begin
          readdata[FIFO_AW:0] = r_level;
          readdata[8]         = w_empty;
          readdata[9]         = w_full;
          readdata[10]        = r_overflow;
        end
        3'd2: readdata = {24'd0, r_rmask};
        3'd3: readdata = {24'd0, r_fmask};
        3'd4: readdata = w_empty ? 32'd0 : r_mem[r_rd_ptr];
        3'd5: readdata = r_counter;
        default: readdata = 32'd0;
      endcase
    end else begin
      readdata = 32'd0;
    end
  end

endmodule
